// File: rtl/axilite_slave.sv
// axilite_slave: AXI-Lite responder with AW/W/AR/R channels (no B, no RRESP).
// Each accepted write (AW+W, any order) or read (AR) becomes a one-cycle
// backend start pulse. The read response is returned on R once the backend
// signals done. The write and read paths are independent and can overlap.
//
// Ports:
//   axi_aclk, axi_areset      clock, synchronous active-high reset
//   axi_aw*, axi_w*           write address / data channels
//   axi_ar*, axi_r*           read address / data channels
//   bk_wstart/waddr/wdata/wstrb, bk_wdone    backend write request / done
//   bk_rstart/raddr, bk_rdata/bk_rdone       backend read request / done
//   bk_timeout                one-cycle abort pulse (timeout build only)
//
// Optional feature: define AXILITE_SLAVE_TIMEOUT_EN to abort a backend wait
// after TIMEOUT_CYCLES cycles. An aborted read returns TIMEOUT_RDATA.
module axilite_slave
`ifdef AXILITE_SLAVE_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
)
`endif
(
  input  logic        axi_aclk,
  input  logic        axi_areset,
  input  logic        axi_awvalid,
  input  logic [31:0] axi_awaddr,
  output logic        axi_awready,
  input  logic        axi_wvalid,
  input  logic [31:0] axi_wdata,
  input  logic [3:0]  axi_wstrb,
  output logic        axi_wready,
  input  logic        axi_arvalid,
  input  logic [31:0] axi_araddr,
  output logic        axi_arready,
  output logic        axi_rvalid,
  output logic [31:0] axi_rdata,
  input  logic        axi_rready,
  output logic        bk_wstart,
  output logic [31:0] bk_waddr,
  output logic [31:0] bk_wdata,
  output logic [3:0]  bk_wstrb,
  input  logic        bk_wdone,
  output logic        bk_rstart,
  output logic [31:0] bk_raddr,
  input  logic [31:0] bk_rdata,
  input  logic        bk_rdone
`ifdef AXILITE_SLAVE_TIMEOUT_EN
  ,
  output logic        bk_timeout
`endif
);

  typedef enum logic [1:0] {WrIdle, WrStart, WrWait} wr_state_e;
  typedef enum logic [1:0] {RdIdle, RdStart, RdWait, RdResp} rd_state_e;

  wr_state_e   wr_state_q, wr_state_d;
  rd_state_e   rd_state_q, rd_state_d;
  logic        aw_got_q, aw_got_d;
  logic        w_got_q, w_got_d;
  logic [31:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] raddr_q, raddr_d;
  logic [31:0] rdata_q, rdata_d;

  logic aw_rdy, w_rdy, ar_rdy;
  logic aw_hs, w_hs, ar_hs;

  // Readies come from registers only; reset masks them so that every output
  // reads zero while reset is held.
  assign aw_rdy = !axi_areset && (wr_state_q == WrIdle) && !aw_got_q;
  assign w_rdy  = !axi_areset && (wr_state_q == WrIdle) && !w_got_q;
  assign ar_rdy = !axi_areset && (rd_state_q == RdIdle);
  assign aw_hs  = axi_awvalid && aw_rdy;
  assign w_hs   = axi_wvalid && w_rdy;
  assign ar_hs  = axi_arvalid && ar_rdy;

`ifdef AXILITE_SLAVE_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic            wr_to_q, wr_to_d, rd_to_q, rd_to_d;
`endif

  // Write path.
  always_comb begin
    wr_state_d = wr_state_q;
    aw_got_d   = aw_got_q;
    w_got_d    = w_got_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    unique case (wr_state_q)
      WrIdle: begin
        if (aw_hs) begin
          aw_got_d = 1'b1;
          waddr_d  = axi_awaddr;
        end
        if (w_hs) begin
          w_got_d = 1'b1;
          wdata_d = axi_wdata;
          wstrb_d = axi_wstrb;
        end
        if ((aw_got_q || aw_hs) && (w_got_q || w_hs)) wr_state_d = WrStart;
      end
      WrStart: begin
        if (bk_wdone) begin
          wr_state_d = WrIdle;
          aw_got_d   = 1'b0;
          w_got_d    = 1'b0;
        end else begin
          wr_state_d = WrWait;
        end
      end
      WrWait: begin
        if (bk_wdone) begin
          wr_state_d = WrIdle;
          aw_got_d   = 1'b0;
          w_got_d    = 1'b0;
        end
      end
      default: wr_state_d = WrIdle;
    endcase
`ifdef AXILITE_SLAVE_TIMEOUT_EN
    // A done arriving on the expiry cycle takes priority over the abort.
    wr_to_d = 1'b0;
    if (wr_state_q != WrIdle && !bk_wdone && wr_cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
      wr_to_d    = 1'b1;
      wr_state_d = WrIdle;
      aw_got_d   = 1'b0;
      w_got_d    = 1'b0;
    end
    wr_cnt_d = (wr_state_q != WrIdle && wr_state_d != WrIdle) ? wr_cnt_q + CntW'(1) : '0;
`endif
  end

  // Read path.
  always_comb begin
    rd_state_d = rd_state_q;
    raddr_d    = raddr_q;
    rdata_d    = rdata_q;
    unique case (rd_state_q)
      RdIdle: begin
        if (ar_hs) begin
          raddr_d    = axi_araddr;
          rd_state_d = RdStart;
        end
      end
      RdStart, RdWait: begin
        if (bk_rdone) begin
          rdata_d    = bk_rdata;
          rd_state_d = RdResp;
        end else begin
          rd_state_d = RdWait;
        end
      end
      RdResp: begin
        if (axi_rready) begin
          rd_state_d = RdIdle;
          rdata_d    = 32'h0;
        end
      end
      default: rd_state_d = RdIdle;
    endcase
`ifdef AXILITE_SLAVE_TIMEOUT_EN
    rd_to_d = 1'b0;
    if ((rd_state_q == RdStart || rd_state_q == RdWait) && !bk_rdone &&
        rd_cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
      rd_to_d    = 1'b1;
      rd_state_d = RdResp;
      rdata_d    = TIMEOUT_RDATA;
    end
    rd_cnt_d = ((rd_state_q == RdStart || rd_state_q == RdWait) &&
                (rd_state_d == RdStart || rd_state_d == RdWait)) ? rd_cnt_q + CntW'(1) : '0;
`endif
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      wr_state_q <= WrIdle;
      rd_state_q <= RdIdle;
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
      waddr_q    <= 32'h0;
      wdata_q    <= 32'h0;
      wstrb_q    <= 4'h0;
      raddr_q    <= 32'h0;
      rdata_q    <= 32'h0;
`ifdef AXILITE_SLAVE_TIMEOUT_EN
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      wr_to_q    <= 1'b0;
      rd_to_q    <= 1'b0;
`endif
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      aw_got_q   <= aw_got_d;
      w_got_q    <= w_got_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      raddr_q    <= raddr_d;
      rdata_q    <= rdata_d;
`ifdef AXILITE_SLAVE_TIMEOUT_EN
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_to_q    <= wr_to_d;
      rd_to_q    <= rd_to_d;
`endif
    end
  end

  assign axi_awready = aw_rdy;
  assign axi_wready  = w_rdy;
  assign axi_arready = ar_rdy;
  assign axi_rvalid  = !axi_areset && (rd_state_q == RdResp);
  assign axi_rdata   = axi_areset ? 32'h0 : rdata_q;
  assign bk_wstart   = !axi_areset && (wr_state_q == WrStart);
  assign bk_waddr    = axi_areset ? 32'h0 : waddr_q;
  assign bk_wdata    = axi_areset ? 32'h0 : wdata_q;
  assign bk_wstrb    = axi_areset ? 4'h0 : wstrb_q;
  assign bk_rstart   = !axi_areset && (rd_state_q == RdStart);
  assign bk_raddr    = axi_areset ? 32'h0 : raddr_q;
`ifdef AXILITE_SLAVE_TIMEOUT_EN
  assign bk_timeout  = !axi_areset && (wr_to_q || rd_to_q);
`endif

endmodule

// File: tb/tb_axilite_slave.sv
// Directed bench for axilite_slave. Inputs change 1 time unit after the
// rising edge and outputs are sampled at that same point.
module tb_axilite_slave;

  logic        axi_aclk;
  logic        axi_areset;
  logic        axi_awvalid;
  logic [31:0] axi_awaddr;
  logic        axi_awready;
  logic        axi_wvalid;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_wready;
  logic        axi_arvalid;
  logic [31:0] axi_araddr;
  logic        axi_arready;
  logic        axi_rvalid;
  logic [31:0] axi_rdata;
  logic        axi_rready;
  logic        bk_wstart;
  logic [31:0] bk_waddr;
  logic [31:0] bk_wdata;
  logic [3:0]  bk_wstrb;
  logic        bk_wdone;
  logic        bk_rstart;
  logic [31:0] bk_raddr;
  logic [31:0] bk_rdata;
  logic        bk_rdone;
`ifdef AXILITE_SLAVE_TIMEOUT_EN
  logic        bk_timeout;
`endif

  int n_checks = 0;
  int n_errors = 0;

`ifdef AXILITE_SLAVE_TIMEOUT_EN
  axilite_slave #(
    .TIMEOUT_CYCLES(8),
    .TIMEOUT_RDATA (32'hDEAD_BEEF)
  ) dut (
`else
  axilite_slave dut (
`endif
    .axi_aclk   (axi_aclk),
    .axi_areset (axi_areset),
    .axi_awvalid(axi_awvalid),
    .axi_awaddr (axi_awaddr),
    .axi_awready(axi_awready),
    .axi_wvalid (axi_wvalid),
    .axi_wdata  (axi_wdata),
    .axi_wstrb  (axi_wstrb),
    .axi_wready (axi_wready),
    .axi_arvalid(axi_arvalid),
    .axi_araddr (axi_araddr),
    .axi_arready(axi_arready),
    .axi_rvalid (axi_rvalid),
    .axi_rdata  (axi_rdata),
    .axi_rready (axi_rready),
    .bk_wstart  (bk_wstart),
    .bk_waddr   (bk_waddr),
    .bk_wdata   (bk_wdata),
    .bk_wstrb   (bk_wstrb),
    .bk_wdone   (bk_wdone),
    .bk_rstart  (bk_rstart),
    .bk_raddr   (bk_raddr),
    .bk_rdata   (bk_rdata),
    .bk_rdone   (bk_rdone)
`ifdef AXILITE_SLAVE_TIMEOUT_EN
    ,
    .bk_timeout (bk_timeout)
`endif
  );

  initial axi_aclk = 1'b0;
  always #5 axi_aclk = ~axi_aclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge axi_aclk);
    #1;
  endtask

  initial begin
    axi_areset  = 1'b1;
    axi_awvalid = 1'b0;
    axi_awaddr  = 32'h0;
    axi_wvalid  = 1'b0;
    axi_wdata   = 32'h0;
    axi_wstrb   = 4'h0;
    axi_arvalid = 1'b0;
    axi_araddr  = 32'h0;
    axi_rready  = 1'b0;
    bk_wdone    = 1'b0;
    bk_rdata    = 32'h0;
    bk_rdone    = 1'b0;

    // Reset: all outputs low while held, readies up right after release.
    repeat (3) tick();
    check("rst_awready", axi_awready, 0);
    check("rst_wready", axi_wready, 0);
    check("rst_arready", axi_arready, 0);
    check("rst_rvalid", axi_rvalid, 0);
    check("rst_wstart", bk_wstart, 0);
    axi_areset = 1'b0;
    #1;
    check("rel_awready", axi_awready, 1);
    check("rel_wready", axi_wready, 1);
    check("rel_arready", axi_arready, 1);

    // Same-cycle AW and W at N.
    axi_awvalid = 1'b1; axi_awaddr = 32'h0000_1000;
    axi_wvalid  = 1'b1; axi_wdata  = 32'hA5A5_5A5A; axi_wstrb = 4'hF;
    tick();  // N+1
    axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    check("t1_wstart", bk_wstart, 1);
    check("t1_waddr", bk_waddr, 32'h0000_1000);
    check("t1_wdata", bk_wdata, 32'hA5A5_5A5A);
    check("t1_wstrb", bk_wstrb, 4'hF);
    check("t1_awready_busy", axi_awready, 0);
    tick();  // N+2
    check("t1_wstart_pulse", bk_wstart, 0);
    tick();  // N+3
    bk_wdone = 1'b1;
    check("t1_wready_wait", axi_wready, 0);
    tick();  // N+4
    bk_wdone = 1'b0;
    check("t1_awready_back", axi_awready, 1);
    check("t1_wready_back", axi_wready, 1);

    // W three cycles ahead of AW; done in the start cycle.
    axi_wvalid = 1'b1; axi_wdata = 32'h1122_3344; axi_wstrb = 4'h3;
    tick();
    axi_wvalid = 1'b0;
    check("t2_wready_drop", axi_wready, 0);
    check("t2_awready_up", axi_awready, 1);
    tick();
    tick();
    axi_awvalid = 1'b1; axi_awaddr = 32'h20;
    check("t2_no_early_start", bk_wstart, 0);
    tick();
    axi_awvalid = 1'b0;
    check("t2_wstart", bk_wstart, 1);
    check("t2_waddr", bk_waddr, 32'h20);
    check("t2_wstrb", bk_wstrb, 4'h3);
    check("t2_wdata", bk_wdata, 32'h1122_3344);
    bk_wdone = 1'b1;
    tick();
    bk_wdone = 1'b0;
    check("t2_fast_done_awready", axi_awready, 1);
    check("t2_fast_done_wready", axi_wready, 1);
    check("t2_wstart_off", bk_wstart, 0);
    check("t2_waddr_hold", bk_waddr, 32'h20);

    // Read with R backpressure.
    axi_arvalid = 1'b1; axi_araddr = 32'h44;
    tick();  // N+1
    axi_arvalid = 1'b0;
    check("t3_rstart", bk_rstart, 1);
    check("t3_raddr", bk_raddr, 32'h44);
    check("t3_arready_busy", axi_arready, 0);
    tick();  // N+2
    bk_rdone = 1'b1; bk_rdata = 32'h1234_5678;
    check("t3_rstart_pulse", bk_rstart, 0);
    check("t3_rvalid_early", axi_rvalid, 0);
    tick();  // N+3
    bk_rdone = 1'b0; bk_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      check("t3_rvalid_hold", axi_rvalid, 1);
      check("t3_rdata_hold", axi_rdata, 32'h1234_5678);
      tick();
    end
    axi_rready = 1'b1;
    check("t3_rvalid_hs", axi_rvalid, 1);
    tick();
    axi_rready = 1'b0;
    check("t3_rvalid_done", axi_rvalid, 0);
    check("t3_rdata_clr", axi_rdata, 0);
    check("t3_arready_back", axi_arready, 1);
    check("t3_raddr_hold", bk_raddr, 32'h44);

    // Concurrent write and read; read completes first.
    axi_awvalid = 1'b1; axi_awaddr = 32'h100; axi_wvalid = 1'b1;
    axi_wdata = 32'h0BAD_CAFE; axi_wstrb = 4'hC;
    axi_arvalid = 1'b1; axi_araddr = 32'h200;
    tick();
    axi_awvalid = 1'b0; axi_wvalid = 1'b0; axi_arvalid = 1'b0;
    check("t4_wstart", bk_wstart, 1);
    check("t4_rstart", bk_rstart, 1);
    tick();
    bk_rdone = 1'b1; bk_rdata = 32'hCAFE_F00D;
    tick();
    bk_rdone = 1'b0;
    check("t4_rvalid", axi_rvalid, 1);
    check("t4_awready_pending", axi_awready, 0);
    bk_wdone = 1'b1;
    tick();
    bk_wdone = 1'b0;
    check("t4_awready_back", axi_awready, 1);
    check("t4_rvalid_still", axi_rvalid, 1);
    check("t4_rdata", axi_rdata, 32'hCAFE_F00D);
    axi_rready = 1'b1;
    tick();
    axi_rready = 1'b0;
    check("t4_rvalid_done", axi_rvalid, 0);
    // Stray done pulses while idle.
    bk_rdone = 1'b1; bk_rdata = 32'h55; bk_wdone = 1'b1;
    tick();
    bk_rdone = 1'b0; bk_wdone = 1'b0;
    tick();
    check("t4_stray_rvalid", axi_rvalid, 0);
    check("t4_stray_rdata", axi_rdata, 0);
    check("t4_stray_arready", axi_arready, 1);
    check("t4_stray_awready", axi_awready, 1);

    // Reset while both paths are waiting.
    axi_awvalid = 1'b1; axi_awaddr = 32'h300; axi_wvalid = 1'b1; axi_wstrb = 4'h1;
    axi_arvalid = 1'b1; axi_araddr = 32'h400;
    tick();
    axi_awvalid = 1'b0; axi_wvalid = 1'b0; axi_arvalid = 1'b0;
    tick();
    axi_areset = 1'b1;
    #1;
    check("t5_awready", axi_awready, 0);
    check("t5_arready", axi_arready, 0);
    check("t5_waddr", bk_waddr, 0);
    check("t5_wstrb", bk_wstrb, 0);
    check("t5_raddr", bk_raddr, 0);
    check("t5_rvalid", axi_rvalid, 0);
    tick();
    axi_areset = 1'b0;
    #1;
    check("t5_rel_awready", axi_awready, 1);
    check("t5_rel_wready", axi_wready, 1);
    check("t5_rel_arready", axi_arready, 1);
    bk_rdone = 1'b1; bk_rdata = 32'h77; bk_wdone = 1'b1;
    tick();
    bk_rdone = 1'b0; bk_wdone = 1'b0;
    tick();
    check("t5_late_rvalid", axi_rvalid, 0);
    check("t5_late_rdata", axi_rdata, 0);
    check("t5_late_awready", axi_awready, 1);

`ifdef AXILITE_SLAVE_TIMEOUT_EN
    // Read timeout with no done.
    axi_arvalid = 1'b1; axi_araddr = 32'h500;
    tick();  // N+1
    axi_arvalid = 1'b0;
    repeat (7) tick();  // N+8
    check("to_not_yet", bk_timeout, 0);
    check("to_rvalid_not_yet", axi_rvalid, 0);
    tick();  // N+9
    check("to_pulse", bk_timeout, 1);
    check("to_rvalid", axi_rvalid, 1);
    check("to_rdata", axi_rdata, 32'hDEAD_BEEF);
    axi_rready = 1'b1;
    tick();
    axi_rready = 1'b0;
    check("to_pulse_end", bk_timeout, 0);
    check("to_rvalid_end", axi_rvalid, 0);
    // Done on the expiry cycle wins.
    axi_arvalid = 1'b1; axi_araddr = 32'h600;
    tick();
    axi_arvalid = 1'b0;
    repeat (7) tick();
    bk_rdone = 1'b1; bk_rdata = 32'h0000_600D;
    tick();
    bk_rdone = 1'b0;
    check("tw_no_timeout", bk_timeout, 0);
    check("tw_rvalid", axi_rvalid, 1);
    check("tw_rdata", axi_rdata, 32'h0000_600D);
    axi_rready = 1'b1;
    tick();
    axi_rready = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axilite_slave.md
Name: axilite_slave

Overview:
- AXI-Lite responder; the counterpart of the fsic axilite master. It accepts AW/W/AR handshakes from an AXI-Lite initiator and turns each into a single-cycle backend start pulse (bk_wstart/bk_rstart).
- It waits for the backend done pulse and returns read data on the R channel.
- Channel set matches the fsic master: AW, W, AR, R only. No B channel, no RRESP.
- Write and read paths are fully independent and run concurrently.

Parameters:
- TIMEOUT_CYCLES, 256: backend wait limit in cycles. Used only with AXILITE_SLAVE_TIMEOUT_EN.
- TIMEOUT_RDATA, 32'hDEAD_BEEF: rdata returned on a read timeout. Used only with AXILITE_SLAVE_TIMEOUT_EN.

Ports:
- axi_aclk  in  1  clock; sole clock domain.
- axi_areset  in  1  synchronous, active-high reset.
- axi_awvalid  in  1  write address valid.
- axi_awaddr  in  32  write address.
- axi_awready  out  1  write address ready.
- axi_wvalid  in  1  write data valid.
- axi_wdata  in  32  write data.
- axi_wstrb  in  4  write byte strobes.
- axi_wready  out  1  write data ready.
- axi_arvalid  in  1  read address valid.
- axi_araddr  in  32  read address.
- axi_arready  out  1  read address ready.
- axi_rvalid  out  1  read data valid.
- axi_rdata  out  32  read data.
- axi_rready  in  1  read data ready.
- bk_wstart  out  1  one-cycle write request pulse.
- bk_waddr  out  32  captured write address.
- bk_wdata  out  32  captured write data.
- bk_wstrb  out  4  captured write strobes.
- bk_wdone  in  1  backend write complete pulse.
- bk_rstart  out  1  one-cycle read request pulse.
- bk_raddr  out  32  captured read address.
- bk_rdata  in  32  backend read data; valid only with bk_rdone.
- bk_rdone  in  1  backend read complete pulse.
- bk_timeout  out  1  timeout pulse; port exists only with AXILITE_SLAVE_TIMEOUT_EN.

Behaviour:
- Reset: while axi_areset=1 every output is 0 (all readies, axi_rvalid, axi_rdata, bk_* outputs) and both FSMs go to IDLE. Reset asserted mid-transaction abandons it with no done/response.
- First cycle after reset: awready=wready=arready=1.
- Write FSM, states WR_IDLE, WR_START, WR_WAIT:
  - Two flags, aw_got and w_got, record captured channels.
  - axi_awready = (WR_IDLE && !aw_got); axi_wready = (WR_IDLE && !w_got). Both are decoded from registers, with no combinational path from the valids.
  - AW handshake captures awaddr into bk_waddr and sets aw_got. W handshake captures wdata/wstrb into bk_wdata/bk_wstrb and sets w_got.
  - AW and W may arrive in either order or in the same cycle.
  - WR_IDLE -> WR_START in the cycle both channels are captured (same-cycle arrival counts).
  - WR_START: bk_wstart=1 for exactly one cycle. Move to WR_WAIT, or straight to WR_IDLE if bk_wdone=1 that cycle.
  - WR_WAIT -> WR_IDLE on bk_wdone; clear aw_got/w_got.
  - bk_wdone in WR_IDLE is ignored.
  - Latency: last of AW/W handshake at cycle N gives bk_wstart at N+1. bk_wdone at cycle M gives readies back at M+1.
- Read FSM, states RD_IDLE, RD_START, RD_WAIT, RD_RESP:
  - axi_arready = RD_IDLE.
  - AR handshake captures araddr into bk_raddr; RD_IDLE -> RD_START.
  - RD_START: bk_rstart=1 for one cycle, then RD_WAIT.
  - bk_rdone in RD_START or RD_WAIT captures bk_rdata into axi_rdata and moves to RD_RESP. bk_rdone in RD_IDLE or RD_RESP is ignored.
  - RD_RESP: axi_rvalid=1, axi_rdata held stable until axi_rready=1; then RD_IDLE. axi_rdata returns to 0 that same edge.
  - Latency: AR handshake at N gives bk_rstart at N+1. bk_rdone at M gives rvalid at M+1.
- bk_waddr, bk_wdata, bk_wstrb and bk_raddr hold their last captured value between transactions.
- Concurrency: a write and a read may be outstanding together. bk_wstart and bk_rstart may pulse in the same cycle.

Optional Feature:
- Macro: AXILITE_SLAVE_TIMEOUT_EN.
- Defined:
  - A per-path counter runs in START/WAIT states and clears when the path leaves them.
  - If done has not arrived after TIMEOUT_CYCLES cycles counted from the START cycle, the path aborts and bk_timeout pulses for 1 cycle.
  - Write abort: go to WR_IDLE and clear the flags.
  - Read abort: go to RD_RESP with axi_rdata=TIMEOUT_RDATA.
  - A done arriving in the same cycle as expiry wins; no timeout is raised.
  - A late done after an abort is ignored.
- Undefined: no counters, no bk_timeout port; both paths wait for done indefinitely.

Test Plan:
- AW(0x0000_1000) and W(0xA5A5_5A5A, strb 0xF) in the same cycle N -> bk_wstart at N+1 with those values; bk_wdone at N+3 -> awready=wready=1 at N+4.
- W (strb 0x3) arrives 3 cycles before AW(0x20) -> wready drops after the W handshake, bk_wstart one cycle after AW, bk_wstrb=0x3.
- AR(0x44) at N, bk_rdone with rdata 0x1234_5678 at N+2, rready held low 4 cycles -> rvalid=1 with rdata stable from N+3 until the rready handshake, then rvalid=0 and arready=1.
- Concurrent write and read issued the same cycle -> both bk_wstart and bk_rstart pulse at N+1; completions in either order are handled independently. Stray bk_rdone in RD_IDLE -> no rvalid.
- axi_areset pulsed during RD_WAIT and during WR_WAIT -> all outputs 0; idle with readies=1 the cycle after release; a subsequent bk_rdone is ignored.
- Built with AXILITE_SLAVE_TIMEOUT_EN, TIMEOUT_CYCLES=8, no bk_rdone -> bk_timeout pulse, rvalid with rdata 0xDEAD_BEEF. Same setup with bk_rdone on the expiry cycle -> real data returned and no bk_timeout.
